// File: rtl/pc_pkg.sv
// pc_pkg: shared source encoding and default constants for the program-counter generator
package pc_pkg;
    typedef enum logic [2:0] {
        SRC_RST,
        SRC_SEQ,
        SRC_BRANCH,
        SRC_CALL,
        SRC_RET,
        SRC_TRAP,
        SRC_ERET
    } pc_src_e;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_STEP       = 1;
    localparam int DEF_RESET_ADDR = 0;
    localparam int DEF_TRAP_VEC   = 'h10;
    localparam int DEF_RAS_DEPTH  = 4;
endpackage

// File: rtl/pc_if.sv
// pc_if: fetch-control bundle between pipeline control and the pc generator
interface pc_if import pc_pkg::*; #(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) ();
    logic                         pc_enable;
    logic                         trap_req;
    logic                         eret;
    logic                         branch_true;
    logic [ADDR_W-1:0]            new_addr;
    logic                         call_in;
    logic                         ret_in;
    logic [ADDR_W-1:0]            call_addr;
    logic [ADDR_W-1:0]            pc_output;
    pc_src_e                      pc_src;
    logic [ADDR_W-1:0]            epc;
    logic [$clog2(RAS_DEPTH):0]   ras_count;
    logic                         ras_underflow;
    logic                         ras_overflow;
    modport master (
        output pc_enable, trap_req, eret, branch_true, new_addr, call_in, ret_in, call_addr,
        input  pc_output, pc_src, epc, ras_count, ras_underflow, ras_overflow
    );
    modport slave (
        input  pc_enable, trap_req, eret, branch_true, new_addr, call_in, ret_in, call_addr,
        output pc_output, pc_src, epc, ras_count, ras_underflow, ras_overflow
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          top_data,
    output logic [$clog2(RAS_DEPTH):0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
    assign top_data = mem_q[ptr_q - PW'(1)];
    assign count    = cnt_q;
    assign empty    = cnt_q == '0;
    assign full     = cnt_q == DEPTH_C;
    // ptr_q names the next free slot; wrapping it lets a full push drop the oldest entry
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            cnt_d        = full ? cnt_q : cnt_q + 1'b1;
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - 1'b1;
        end
    end
    // pointer and occupancy reset; stack contents are don't-care after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
    // entry storage carries no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: prioritised next-fetch-address selection with exception PC and return stack
module pc_gen import pc_pkg::*; #(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                STEP       = DEF_STEP,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR),
    parameter logic [ADDR_W-1:0] TRAP_VEC   = ADDR_W'(DEF_TRAP_VEC),
    parameter int                RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input logic clk,
    input logic rst,
    pc_if.slave bus
);
    logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d, seq_addr, ras_top;
    pc_src_e           src_q, src_d;
    logic              under_q, under_d, over_q, over_d;
    logic              push, pop, ras_empty, ras_full;
    assign seq_addr = pc_q + ADDR_W'(STEP);
    pc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (seq_addr),
        .top_data  (ras_top),
        .count     (bus.ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );
    // flushes win over stalls; call/ret/seq only advance when enabled, and only the winner touches the RAS
    always_comb begin
        pc_d    = pc_q;
        src_d   = src_q;
        epc_d   = epc_q;
        push    = 1'b0;
        pop     = 1'b0;
        under_d = 1'b0;
        over_d  = 1'b0;
        if (bus.trap_req) begin
            pc_d  = TRAP_VEC;
            epc_d = pc_q;
            src_d = SRC_TRAP;
        end else if (bus.eret) begin
            pc_d  = epc_q;
            src_d = SRC_ERET;
        end else if (bus.branch_true) begin
            pc_d  = bus.new_addr;
            src_d = SRC_BRANCH;
        end else if (bus.pc_enable) begin
            if (bus.call_in) begin
                push   = 1'b1;
                over_d = ras_full;
                pc_d   = bus.call_addr;
                src_d  = SRC_CALL;
            end else if (bus.ret_in) begin
                pop     = !ras_empty;
                under_d = ras_empty;
                pc_d    = ras_empty ? seq_addr : ras_top;
                src_d   = SRC_RET;
            end else begin
                pc_d  = seq_addr;
                src_d = SRC_SEQ;
            end
        end
    end
    // architectural PC state and registered RAS error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_ADDR;
            src_q   <= SRC_RST;
            epc_q   <= '0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            src_q   <= src_d;
            epc_q   <= epc_d;
            under_q <= under_d;
            over_q  <= over_d;
        end
    end
    assign bus.pc_output     = pc_q;
    assign bus.pc_src        = src_q;
    assign bus.epc           = epc_q;
    assign bus.ras_underflow = under_q;
    assign bus.ras_overflow  = over_q;
endmodule
